fpu_share_arbiter: RTL

Arbitrates one shared, multi-cycle FPU between the two cores of the RV32IMFA dual-core pipeline. Each core's execute stage raises a request for every instruction its decoder flags as FPU work. The arbiter grants requests round-robin, launches the FPU with registered operands, and waits for completion. It then returns result, flags and destination tag to the owning core over a valid/ready response channel. One operation is in flight at a time.

---
 rtl/fpu_arb_pkg.sv | 19 +
 rtl/fpu_share_arbiter_rr_arb2.sv | 22 ++
 rtl/fpu_share_arbiter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/fpu_arb_pkg.sv
// Shared types and constants for the dual-core FPU share arbiter.
// Holds the arbiter state encoding, field widths and the canonical NaN/flag values.
package fpu_arb_pkg;

    localparam int OP_W   = 5;
    localparam int RM_W   = 3;
    localparam int TAG_W  = 5;
    localparam int FLAG_W = 5;

    localparam logic [31:0]       CANON_NAN = 32'h7FC0_0000;
    localparam logic [FLAG_W-1:0] FLAG_NV   = 5'b10000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/fpu_share_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to the
// core that did not own the previous operation. Purely combinational.
module rr_arb2 (
    input  logic [1:0] req_valid,
    input  logic       last_owner,
    input  logic       idle,
    output logic [1:0] grant
);

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        grant = 2'b00;
        if (idle) begin
            if (req_valid == 2'b11) begin
                grant = last_owner ? 2'b01 : 2'b10;
            end else begin
                grant = req_valid;
            end
        end
    end

endmodule

// File: rtl/fpu_share_arbiter.sv
// Shares one multi-cycle FPU between two cores: round-robin accept, registered
// launch, completion wait, one-hot valid/ready response. Watchdog: FPU_ARB_TIMEOUT_EN.
module fpu_share_arbiter
    import fpu_arb_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [2*OP_W-1:0]    req_op,
    input  logic [2*RM_W-1:0]    req_rm,
    input  logic [2*TAG_W-1:0]   req_rd,
    input  logic [2*XLEN-1:0]    req_a,
    input  logic [2*XLEN-1:0]    req_b,
    input  logic [2*XLEN-1:0]    req_c,
    output logic                 fpu_start,
    output logic [OP_W-1:0]      fpu_op,
    output logic [RM_W-1:0]      fpu_rm,
    output logic [XLEN-1:0]      fpu_a,
    output logic [XLEN-1:0]      fpu_b,
    output logic [XLEN-1:0]      fpu_c,
    input  logic                 fpu_done,
    input  logic [XLEN-1:0]      fpu_result,
    input  logic [FLAG_W-1:0]    fpu_flags,
    output logic [1:0]           resp_valid,
    input  logic [1:0]           resp_ready,
    output logic [XLEN-1:0]      resp_data,
    output logic [FLAG_W-1:0]    resp_flags,
    output logic [TAG_W-1:0]     resp_rd,
    output logic                 resp_err
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("fpu_share_arbiter: TIMEOUT_CYCLES must be at least 2");
    end

    arb_state_e        state_q;
    logic              owner_q;
    logic              last_owner_q;
    logic              start_q;
    logic [OP_W-1:0]   op_q;
    logic [RM_W-1:0]   rm_q;
    logic [TAG_W-1:0]  tag_q;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;
    logic [XLEN-1:0]   c_q;
    logic [1:0]        resp_valid_q;
    logic [XLEN-1:0]   resp_data_q;
    logic [FLAG_W-1:0] resp_flags_q;

    logic [1:0]        grant;
    logic              accept;
    logic              done_ok;
    logic              timeout_hit;
    logic [OP_W-1:0]   op_d;
    logic [RM_W-1:0]   rm_d;
    logic [TAG_W-1:0]  tag_d;
    logic [XLEN-1:0]   a_d;
    logic [XLEN-1:0]   b_d;
    logic [XLEN-1:0]   c_d;

    rr_arb2 u_rr_arb2 (
        .req_valid  (req_valid),
        .last_owner (last_owner_q),
        .idle       (state_q == ST_IDLE && !rst),
        .grant      (grant)
    );

    assign req_ready = grant;
    assign accept    = |grant;

    // A done on the launch cycle belongs to nothing we issued and is dropped.
    assign done_ok = fpu_done && !start_q;

    assign op_d  = grant[1] ? req_op[OP_W +: OP_W]   : req_op[0 +: OP_W];
    assign rm_d  = grant[1] ? req_rm[RM_W +: RM_W]   : req_rm[0 +: RM_W];
    assign tag_d = grant[1] ? req_rd[TAG_W +: TAG_W] : req_rd[0 +: TAG_W];
    assign a_d   = grant[1] ? req_a[XLEN +: XLEN]    : req_a[0 +: XLEN];
    assign b_d   = grant[1] ? req_b[XLEN +: XLEN]    : req_b[0 +: XLEN];
    assign c_d   = grant[1] ? req_c[XLEN +: XLEN]    : req_c[0 +: XLEN];

`ifdef FPU_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] busy_cnt_q;
    logic             resp_err_q;

    assign timeout_hit = (state_q == ST_BUSY) && (busy_cnt_q == CNT_W'(TIMEOUT_CYCLES));

    // The count reads 1 on the launch cycle and freezes once BUSY is left.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_cnt_q <= '0;
            resp_err_q <= 1'b0;
        end else if (state_q == ST_IDLE && accept) begin
            busy_cnt_q <= CNT_W'(1);
        end else if (state_q == ST_BUSY) begin
            if (done_ok) begin
                resp_err_q <= 1'b0;
            end else if (timeout_hit) begin
                resp_err_q <= 1'b1;
            end else begin
                busy_cnt_q <= busy_cnt_q + CNT_W'(1);
            end
        end
    end

    assign resp_err = resp_err_q;
`else
    assign timeout_hit = 1'b0;
    assign resp_err    = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            start_q      <= 1'b0;
            op_q         <= '0;
            rm_q         <= '0;
            tag_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            c_q          <= '0;
            resp_valid_q <= 2'b00;
            resp_data_q  <= '0;
            resp_flags_q <= '0;
        end else begin
            start_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        owner_q <= grant[1];
                        op_q    <= op_d;
                        rm_q    <= rm_d;
                        tag_q   <= tag_d;
                        a_q     <= a_d;
                        b_q     <= b_d;
                        c_q     <= c_d;
                        start_q <= 1'b1;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (done_ok) begin
                        resp_data_q  <= fpu_result;
                        resp_flags_q <= fpu_flags;
                        resp_valid_q <= owner_q ? 2'b10 : 2'b01;
                        state_q      <= ST_RESP;
                    end else if (timeout_hit) begin
                        resp_data_q  <= XLEN'(CANON_NAN);
                        resp_flags_q <= FLAG_NV;
                        resp_valid_q <= owner_q ? 2'b10 : 2'b01;
                        state_q      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_ready[owner_q]) begin
                        resp_valid_q <= 2'b00;
                        last_owner_q <= owner_q;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign fpu_start  = start_q;
    assign fpu_op     = op_q;
    assign fpu_rm     = rm_q;
    assign fpu_a      = a_q;
    assign fpu_b      = b_q;
    assign fpu_c      = c_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_flags = resp_flags_q;
    assign resp_rd    = tag_q;

endmodule
